// File: rtl/sysid_pkg.sv
// sysid_pkg: shared FSM states, fail codes and sysid slave address map.
package sysid_pkg;
  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, DONE} state_t;
  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ID      = 2'b01;
  localparam logic [1:0] FC_TS      = 2'b10;
  localparam logic [1:0] FC_TIMEOUT = 2'b11;
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;
endpackage

// File: rtl/avmm_read_seq.sv
// avmm_read_seq: issues one Avalon-MM read, times read latency and waitrequest stalls.
// Ports: issue/addr start a read; av_read/av_address drive the bus; av_waitrequest stalls it;
// capture marks the cycle readdata is valid; timeout fires on the last allowed stall cycle.
module avmm_read_seq #(
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic issue,
  input  logic addr,
  input  logic av_waitrequest,
  output logic av_read,
  output logic av_address,
  output logic capture,
  output logic timeout
);
  logic [15:0] wait_cnt;
  logic [2:0]  lat_cnt;
  logic        lat;
  logic        accept;
  assign accept  = av_read && !av_waitrequest;
  assign timeout = av_read && av_waitrequest && wait_cnt == 16'(TIMEOUT_CYCLES - 1);
  // zero latency: data is valid in the accept cycle itself
  assign capture = READ_LATENCY == 0 ? accept : lat && lat_cnt == 3'(READ_LATENCY);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      av_read    <= 1'b0;
      av_address <= 1'b0;
      wait_cnt   <= '0;
      lat        <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      if (issue) begin
        av_read    <= 1'b1;
        av_address <= addr;
        wait_cnt   <= '0;
      end else if (accept || timeout) begin
        av_read  <= 1'b0;
        wait_cnt <= '0;
      end else if (av_read) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (accept && READ_LATENCY != 0) begin
        lat     <= 1'b1;
        lat_cnt <= 3'd1;
      end else if (capture) begin
        lat <= 1'b0;
      end else if (lat) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
    end
  end
endmodule

// File: rtl/sysid_verify.sv
// sysid_verify: reads the sysid ID and timestamp words and checks them against expected values.
// Ports: start re-runs a check from DONE; av_* is the Avalon-MM read master;
// done/pass/fail/fail_code report the result; id_value/ts_value hold the last captured words.
module sysid_verify
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1396564150,
  parameter int unsigned READ_LATENCY       = 1,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  state_t     state;
  logic [3:0] retries;
  logic       capture, timeout, issue, retry, id_phase, id_bad, ts_bad;
  assign id_phase = state == RD_ID || state == LAT_ID;
  assign id_bad   = id_value != EXPECTED_ID;
  assign ts_bad   = ts_value != EXPECTED_TIMESTAMP;
  assign retry    = state == CHECK && (id_bad || ts_bad) && retries < 4'(MAX_RETRIES);
  // a new read starts on leaving IDLE, on a retry, and right after the ID word lands
  assign issue    = state == IDLE || retry || (id_phase && capture);
  avmm_read_seq #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_seq (
    .clock         (clock),
    .reset_n       (reset_n),
    .issue         (issue),
    .addr          (id_phase ? ADDR_TS : ADDR_ID),
    .av_waitrequest(av_waitrequest),
    .av_read       (av_read),
    .av_address    (av_address),
    .capture       (capture),
    .timeout       (timeout)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      retries   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= FC_NONE;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state   <= RD_ID;
          retries <= '0;
        end
        RD_ID, LAT_ID, RD_TS, LAT_TS: begin
          if (timeout) begin
            state     <= DONE;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= FC_TIMEOUT;
          end else if (capture) begin
            if (id_phase) id_value <= av_readdata;
            else ts_value <= av_readdata;
            state <= id_phase ? RD_TS : CHECK;
          end else if ((state == RD_ID || state == RD_TS) && !av_waitrequest) begin
            state <= id_phase ? LAT_ID : LAT_TS;
          end
        end
        CHECK: begin
          if (!id_bad && !ts_bad) begin
            state     <= DONE;
            done      <= 1'b1;
            pass      <= 1'b1;
            fail_code <= FC_NONE;
          end else if (retry) begin
            state   <= RD_ID;
            retries <= retries + 4'd1;
          end else begin
            state     <= DONE;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= id_bad ? FC_ID : FC_TS;
          end
        end
        DONE: begin
          if (start) begin
            state     <= IDLE;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sysid_verify.sv
// tb_sysid_verify: scoreboard bench for sysid_verify at read latencies 1, 0 and 2.
module tb_sysid_verify;
  localparam logic [31:0] TS      = 32'd1396564150;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;
  typedef struct {
    logic        p;
    logic        f;
    logic [1:0]  code;
    logic        words;
    logic [31:0] id;
    logic [31:0] ts;
    int          reads;
    int          base;
  } exp_t;
  exp_t sb[$];
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [2:0] start = '0;
  logic [2:0] stall_all = '0;
  int mode [3] = '{0, 0, 0};
  int stall_n [3] = '{0, 0, 0};
  int ts_base [3] = '{0, 0, 0};
  int id_reads [3] = '{0, 0, 0};
  int ts_reads [3] = '{0, 0, 0};
  int sc [3] = '{0, 0, 0};
  int age [3] = '{0, 0, 0};
  logic [2:0] pend = '0, paddr = '0, pbad = '0;
  logic [2:0] av_read, av_address, av_wait, done, pass, fail;
  logic [1:0] fail_code [3];
  logic [31:0] av_rdata [3], id_v [3], ts_v [3];
  int errors = 0, checks = 0;
  always #5 clock = ~clock;
  function automatic logic [31:0] word(input logic a, input logic bad, input int m);
    return a ? (bad ? TS ^ 32'h1 : TS) : (m == 1 ? 32'd5 : 32'd0);
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = g == 0 ? 1 : g == 1 ? 0 : 2;
    assign av_wait[g] = stall_all[g] || sc[g] < stall_n[g];
    assign av_rdata[g] = LAT == 0
      ? (av_read[g] && !av_wait[g] ? word(av_address[g], mode[g] == 2 && av_address[g] && ts_reads[g] == ts_base[g], mode[g]) : GARBAGE)
      : (pend[g] && age[g] == LAT - 1 ? word(paddr[g], pbad[g], mode[g]) : GARBAGE);
    sysid_verify #(.READ_LATENCY(LAT), .TIMEOUT_CYCLES(g == 0 ? 10 : 255)) dut (
      .clock(clock), .reset_n(reset_n), .start(start[g]),
      .av_address(av_address[g]), .av_read(av_read[g]), .av_waitrequest(av_wait[g]),
      .av_readdata(av_rdata[g]), .done(done[g]), .pass(pass[g]), .fail(fail[g]),
      .fail_code(fail_code[g]), .id_value(id_v[g]), .ts_value(ts_v[g]));
  end
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (av_read[i] && !av_wait[i]) begin
        if (av_address[i]) ts_reads[i] <= ts_reads[i] + 1;
        else id_reads[i] <= id_reads[i] + 1;
        pend[i]  <= 1'b1;
        age[i]   <= 0;
        paddr[i] <= av_address[i];
        pbad[i]  <= mode[i] == 2 && av_address[i] && ts_reads[i] == ts_base[i];
      end else if (pend[i]) age[i] <= age[i] + 1;
      sc[i] <= (av_read[i] && av_wait[i]) ? sc[i] + 1 : 0;
      if (!reset_n) begin
        pend[i] <= 1'b0;
        sc[i]   <= 0;
      end
    end
  end
  task automatic push(input int i, input logic p, input logic f, input logic [1:0] code,
                      input logic words, input logic [31:0] id, input logic [31:0] ts, input int reads);
    exp_t e;
    e.p = p; e.f = f; e.code = code; e.words = words; e.id = id; e.ts = ts;
    e.reads = reads; e.base = id_reads[i];
    sb.push_back(e);
  endtask
  task automatic check_reset_vals(input int i, input string tag);
    checks++;
    if ({done[i], pass[i], fail[i], av_read[i], av_address[i]} !== 5'b0) begin
      errors++;
      $display("FAIL %s[%0d] flags: done/pass/fail/rd/addr=%b want 00000", tag, i, {done[i], pass[i], fail[i], av_read[i], av_address[i]});
    end
    checks++;
    if (fail_code[i] !== 2'b00) begin errors++; $display("FAIL %s[%0d] fail_code: got %b want 00", tag, i, fail_code[i]); end
    checks++;
    if (id_v[i] !== 32'd0 || ts_v[i] !== 32'd0) begin
      errors++;
      $display("FAIL %s[%0d] words: id=%h ts=%h want 0/0", tag, i, id_v[i], ts_v[i]);
    end
  endtask
  task automatic start_run(input int i);
    @(negedge clock) start[i] = 1'b1;
    @(negedge clock) start[i] = 1'b0;
    checks++;
    if ({done[i], pass[i], fail[i], fail_code[i]} !== 5'b0) begin
      errors++;
      $display("FAIL start_clear[%0d]: done/pass/fail/code=%b want 00000", i, {done[i], pass[i], fail[i], fail_code[i]});
    end
  endtask
  task automatic check_done(input int i, input int budget, output int hi);
    exp_t e;
    int n = 0;
    hi = 0;
    while (done[i] !== 1'b1 && n < budget) begin
      if (av_read[i]) hi++;
      @(negedge clock);
      n++;
    end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL scoreboard[%0d]: got empty want entry", i); return; end
    e = sb.pop_front();
    checks++;
    if (done[i] !== 1'b1) begin errors++; $display("FAIL done[%0d]: got %b want 1 within %0d cycles", i, done[i], budget); end
    checks++;
    if ({pass[i], fail[i]} !== {e.p, e.f}) begin
      errors++;
      $display("FAIL pass_fail[%0d]: got %b%b want %b%b", i, pass[i], fail[i], e.p, e.f);
    end
    checks++;
    if (fail_code[i] !== e.code) begin errors++; $display("FAIL fail_code[%0d]: got %b want %b", i, fail_code[i], e.code); end
    checks++;
    if (av_read[i] !== 1'b0) begin errors++; $display("FAIL idle_read[%0d]: got %b want 0", i, av_read[i]); end
    if (e.words) begin
      checks++;
      if (id_v[i] !== e.id) begin errors++; $display("FAIL id_value[%0d]: got %h want %h", i, id_v[i], e.id); end
      checks++;
      if (ts_v[i] !== e.ts) begin errors++; $display("FAIL ts_value[%0d]: got %h want %h", i, ts_v[i], e.ts); end
    end
    if (e.reads >= 0) begin
      checks++;
      if (id_reads[i] - e.base !== e.reads) begin
        errors++;
        $display("FAIL id_reads[%0d]: got %0d want %0d", i, id_reads[i] - e.base, e.reads);
      end
    end
  endtask
  task automatic test_reset;
    int hi;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) check_reset_vals(i, "reset");
    for (int i = 0; i < 3; i++) push(i, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0, TS, 1);
    reset_n = 1'b1;
    check_done(0, 8, hi);
    check_done(1, 40, hi);
    check_done(2, 40, hi);
  endtask
  task automatic test_id_retry;
    int hi;
    mode[0] = 1;
    push(0, 1'b0, 1'b1, 2'b01, 1'b1, 32'd5, TS, 4);
    start_run(0);
    check_done(0, 100, hi);
  endtask
  task automatic test_ts_retry;
    int hi;
    mode[0] = 2;
    ts_base[0] = ts_reads[0];
    push(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0, TS, 2);
    start_run(0);
    check_done(0, 100, hi);
    mode[0] = 0;
  endtask
  task automatic test_timeout;
    int hi;
    stall_all[0] = 1'b1;
    push(0, 1'b0, 1'b1, 2'b11, 1'b0, 32'd0, 32'd0, 0);
    start_run(0);
    check_done(0, 60, hi);
    checks++;
    if (hi !== 10) begin errors++; $display("FAIL timeout_stalls: got %0d want 10", hi); end
    stall_all[0] = 1'b0;
  endtask
  task automatic test_latency_stall;
    int hi;
    for (int i = 1; i < 3; i++) begin
      stall_n[i] = 3;
      push(i, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0, TS, 1);
      start_run(i);
      check_done(i, 60, hi);
    end
  endtask
  task automatic test_start_ignored;
    int hi;
    push(2, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0, TS, 1);
    start_run(2);
    repeat (4) @(negedge clock);
    start[2] = 1'b1;
    @(negedge clock) start[2] = 1'b0;
    check_done(2, 60, hi);
  endtask
  task automatic test_mid_reset;
    int hi, n = 0;
    mode[0] = 1;
    start_run(0);
    while (!(av_read[0] && av_address[0]) && n < 60) begin @(negedge clock); n++; end
    checks++;
    if (!(av_read[0] && av_address[0])) begin errors++; $display("FAIL reach_rd_ts: got rd=%b addr=%b want 11", av_read[0], av_address[0]); end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_vals(0, "mid_reset");
    mode[0] = 0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) push(i, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0, TS, 1);
    reset_n = 1'b1;
    check_done(0, 40, hi);
    check_done(1, 60, hi);
    check_done(2, 60, hi);
  endtask
  initial begin
    test_reset;
    test_id_retry;
    test_ts_retry;
    test_timeout;
    test_latency_stall;
    test_start_ignored;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
